taxi_trip_timer: RTL and testbench

- Parametrised successor to the fare-meter wait timer. Counts trip time as BCD mm:ss from the 100 Hz system clock through an internal seconds prescaler.
- Supports two count modes: wait-only, or wait plus move. Snapshots the final time when the trip ends and emits billing pulses per completed waiting interval.
- Sits between the trip-state FSM and the fare calculator / display driver.

---
 rtl/taxi_trip_timer_if.sv | 20 ++
 rtl/taxi_trip_timer.sv | 126 ++++++++++++
 tb/tb_taxi_trip_timer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/taxi_trip_timer_if.sv
// Trip-state / time-report bundle between the trip FSM, the timer and its consumers.
interface taxi_trip_timer_if;
  logic [1:0]  state;
  logic        move_cnt_en;
  logic [15:0] tm;
  logic [15:0] tm_locked;
  logic        lock_valid;
  logic        sat;
  logic        charge_tick;

  modport master (
    output state, move_cnt_en,
    input  tm, tm_locked, lock_valid, sat, charge_tick
  );

  modport slave (
    input  state, move_cnt_en,
    output tm, tm_locked, lock_valid, sat, charge_tick
  );
endinterface

// File: rtl/taxi_trip_timer.sv
// BCD mm:ss trip timer with a seconds prescaler, trip-end snapshot and
// billing pulses for each completed block of waiting seconds.
module taxi_trip_timer #(
  parameter int TICKS_PER_SEC = 100,
  parameter int MAX_MIN       = 59,
  parameter int CHARGE_SEC    = 180
) (
  input  logic               clk,
  input  logic               rst_n,
  taxi_trip_timer_if.slave   bus
);

  localparam int          PW     = $clog2(TICKS_PER_SEC);
  localparam int          CW     = (CHARGE_SEC > 1) ? $clog2(CHARGE_SEC) : 1;
  localparam logic [15:0] SAT_TM = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10), 8'h59};

  logic [PW-1:0] r_presc;
  logic [CW-1:0] r_chg;
  logic [15:0]   r_tm;
  logic [15:0]   r_tm_locked;
  logic          r_lock_valid;
  logic          r_charge_tick;
  logic          r_prev_idle;

  logic          w_idle;
  logic          w_wait;
  logic          w_move;
  logic          w_active;
  logic          w_sec_tick;
  logic          w_sat;
  logic          w_step;
  logic          w_chg_step;
  logic          w_chg_full;
  logic [3:0]    w_wrap;
  logic [15:0]   w_tm_next;

  // 2'b10 decodes as IDLE, so bit 0 alone separates idle from running.
  assign w_idle     = ~bus.state[0];
  assign w_wait     = (bus.state == 2'b11);
  assign w_move     = (bus.state == 2'b01);
  assign w_active   = w_wait | (w_move & bus.move_cnt_en);
  assign w_sec_tick = w_active & (r_presc == PW'(TICKS_PER_SEC - 1));
  assign w_sat      = (r_tm == SAT_TM);
  assign w_step     = w_sec_tick & ~w_sat;
  assign w_chg_step = w_step & w_wait;
  assign w_chg_full = (r_chg == CW'(CHARGE_SEC - 1));

  // Digit order: s_units, s_tens, m_units, m_tens; each digit advances when all lower ones wrap.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
      localparam logic [3:0] LIM = (gi == 1) ? 4'd5 : 4'd9;
      logic       w_en;
      logic [3:0] w_dig;

      assign w_dig       = r_tm[gi*4 +: 4];
      assign w_wrap[gi]  = (w_dig == LIM);
      if (gi == 0) begin : g_lsd
        assign w_en = w_step;
      end else begin : g_upper
        assign w_en = w_step & (&w_wrap[gi-1:0]);
      end
      assign w_tm_next[gi*4 +: 4] = !w_en      ? w_dig :
                                    w_wrap[gi] ? 4'd0  : w_dig + 4'd1;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
    end else if (w_idle) begin
      r_presc <= '0;
    end else if (w_active) begin
      r_presc <= w_sec_tick ? '0 : r_presc + PW'(1);
    end
  end

  // A tick landing on the IDLE-entry cycle is dropped: w_active is low then.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tm         <= '0;
      r_tm_locked  <= '0;
      r_lock_valid <= 1'b0;
      r_prev_idle  <= 1'b1;
    end else begin
      r_prev_idle <= w_idle;
      if (w_idle) begin
        r_tm <= '0;
        if (!r_prev_idle) begin
          r_tm_locked  <= r_tm;
          r_lock_valid <= 1'b1;
        end
      end else begin
        r_tm <= w_tm_next;
        if (r_prev_idle) begin
          r_lock_valid <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chg         <= '0;
      r_charge_tick <= 1'b0;
    end else begin
      r_charge_tick <= 1'b0;
      if (w_idle) begin
        r_chg <= '0;
      end else if (w_chg_step) begin
        if (w_chg_full) begin
          r_chg         <= '0;
          r_charge_tick <= 1'b1;
        end else begin
          r_chg <= r_chg + CW'(1);
        end
      end
    end
  end

  assign bus.tm          = r_tm;
  assign bus.tm_locked   = r_tm_locked;
  assign bus.lock_valid  = r_lock_valid;
  assign bus.sat         = w_sat;
  assign bus.charge_tick = r_charge_tick;

endmodule

// File: tb/tb_taxi_trip_timer.sv
// Directed bench for taxi_trip_timer: a default instance plus a small
// fast-prescaler instance for the saturation scenario.
module tb_taxi_trip_timer;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] MOVE = 2'b01;
  localparam logic [1:0] WAIT = 2'b11;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  logic [15:0] ct_a[$];
  logic [15:0] ct_b[$];
  int   base;

  taxi_trip_timer_if bus_a();
  taxi_trip_timer_if bus_b();

  taxi_trip_timer #(.TICKS_PER_SEC(100), .MAX_MIN(59), .CHARGE_SEC(180)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  taxi_trip_timer #(.TICKS_PER_SEC(10), .MAX_MIN(1), .CHARGE_SEC(50)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record tm at every billing pulse of each instance.
  always @(negedge clk) begin
    if (bus_a.charge_tick) ct_a.push_back(bus_a.tm);
    if (bus_b.charge_tick) ct_b.push_back(bus_b.tm);
  end

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("check %s ok (0x%0h)", tag, got);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus_a.state = IDLE;
    bus_a.move_cnt_en = 1'b0;
    bus_b.state = IDLE;
    bus_b.move_cnt_en = 1'b0;
    #1;
    chk_val("rst_tm", bus_a.tm, 16'h0000);
    chk_val("rst_locked", bus_a.tm_locked, 16'h0000);
    chk_val("rst_lock_valid", bus_a.lock_valid, 1'b0);
    chk_val("rst_sat", bus_a.sat, 1'b0);
    chk_val("rst_charge", bus_a.charge_tick, 1'b0);
    cyc(2);
    rst_n = 1'b1;

    // 65 s of waiting from a fresh prescaler.
    bus_a.state = WAIT;
    cyc(99);
    chk_val("t1_before_first_sec", bus_a.tm, 16'h0000);
    cyc(1);
    chk_val("t1_first_sec", bus_a.tm, 16'h0001);
    cyc(6400);
    chk_val("t1_tm_65s", bus_a.tm, 16'h0105);
    chk_val("t1_sat", bus_a.sat, 1'b0);
    chk_val("t1_no_charge", ct_a.size(), 0);
    bus_a.state = IDLE;
    cyc(1);
    chk_val("t1_locked", bus_a.tm_locked, 16'h0105);
    chk_val("t1_tm_clr", bus_a.tm, 16'h0000);

    // WAIT 3 s, MOVE 5 s uncounted, WAIT 2 s.
    bus_a.state = WAIT;
    cyc(1);
    chk_val("t2_start_unlock", bus_a.lock_valid, 1'b0);
    cyc(299);
    chk_val("t2_wait3", bus_a.tm, 16'h0003);
    bus_a.state = MOVE;
    cyc(500);
    chk_val("t2_move_hold", bus_a.tm, 16'h0003);
    bus_a.state = WAIT;
    cyc(200);
    chk_val("t2_wait5", bus_a.tm, 16'h0005);
    bus_a.state = IDLE;
    cyc(1);
    chk_val("t2_locked", bus_a.tm_locked, 16'h0005);
    chk_val("t2_lock_valid", bus_a.lock_valid, 1'b1);
    chk_val("t2_tm_clr", bus_a.tm, 16'h0000);

    // Counted MOVE 10 s then WAIT 10 s.
    bus_a.move_cnt_en = 1'b1;
    bus_a.state = MOVE;
    cyc(1000);
    chk_val("t3_move10", bus_a.tm, 16'h0010);
    bus_a.state = WAIT;
    cyc(1000);
    bus_a.state = IDLE;
    cyc(1);
    chk_val("t3_locked", bus_a.tm_locked, 16'h0020);
    bus_a.move_cnt_en = 1'b0;

    // A tick pending on the IDLE-entry cycle must be discarded.
    bus_a.state = WAIT;
    cyc(99);
    bus_a.state = IDLE;
    cyc(1);
    chk_val("t_disc_locked", bus_a.tm_locked, 16'h0000);
    chk_val("t_disc_tm", bus_a.tm, 16'h0000);

    // 400 s of waiting: billing pulses at 3:00 and 6:00.
    base = ct_a.size();
    bus_a.state = WAIT;
    cyc(40000);
    chk_val("t4_tm", bus_a.tm, 16'h0640);
    chk_val("t4_pulses", ct_a.size() - base, 2);
    chk_val("t4_pulse1_tm", (ct_a.size() > base) ? ct_a[base] : 16'hffff, 16'h0300);
    chk_val("t4_pulse2_tm", (ct_a.size() > base + 1) ? ct_a[base+1] : 16'hffff, 16'h0600);
    bus_a.state = IDLE;
    cyc(1);
    chk_val("t4_locked", bus_a.tm_locked, 16'h0640);

    // Saturation at 1:59 on the 10-tick, MAX_MIN=1, CHARGE_SEC=50 instance.
    bus_b.state = WAIT;
    cyc(1189);
    chk_val("t5_tm_118s", bus_b.tm, 16'h0158);
    chk_val("t5_sat_early", bus_b.sat, 1'b0);
    cyc(1);
    chk_val("t5_tm_sat", bus_b.tm, 16'h0159);
    chk_val("t5_sat", bus_b.sat, 1'b1);
    cyc(810);
    chk_val("t5_tm_hold", bus_b.tm, 16'h0159);
    chk_val("t5_pulses", ct_b.size(), 2);
    chk_val("t5_pulse1_tm", (ct_b.size() > 0) ? ct_b[0] : 16'hffff, 16'h0050);
    chk_val("t5_pulse2_tm", (ct_b.size() > 1) ? ct_b[1] : 16'hffff, 16'h0140);
    bus_b.state = IDLE;
    cyc(1);
    chk_val("t5_locked", bus_b.tm_locked, 16'h0159);
    chk_val("t5_sat_clr", bus_b.sat, 1'b0);

    // Asynchronous reset in the middle of a trip.
    bus_a.state = WAIT;
    cyc(1200);
    chk_val("t6_tm_pre", bus_a.tm, 16'h0012);
    chk_val("t6_lock_pre", bus_a.lock_valid, 1'b0);
    chk_val("t6_locked_pre", bus_a.tm_locked, 16'h0640);
    #2;
    rst_n = 1'b0;
    #1;
    chk_val("t6_tm_async", bus_a.tm, 16'h0000);
    chk_val("t6_locked_async", bus_a.tm_locked, 16'h0000);
    chk_val("t6_lv_b_async", bus_b.lock_valid, 1'b0);
    bus_a.state = IDLE;
    cyc(2);
    rst_n = 1'b1;
    cyc(3);
    chk_val("t6_lock_after", bus_a.lock_valid, 1'b0);
    chk_val("t6_locked_after", bus_a.tm_locked, 16'h0000);
    chk_val("t6_tm_after", bus_a.tm, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
